rv32_bus_arbiter: RTL and testbench
===================================

RV32_BUS_ARBITER -- requirements
Module: rv32_bus_arbiter

Interface
REQ-001 Parameter MAX_DATA_STREAK, default 4, meaning: consecutive data grants allowed while fetch waits; legal range 1..15.
REQ-002 clk  in  1  sole clock; all state updates on posedge clk.
REQ-003 reset_n  in  1  asynchronous, active-low reset.
REQ-004 instr_valid  in  1  fetch request; held with instr_addr until instr_ready or instr_abort.
REQ-005 instr_addr  in  32  fetch word address.
REQ-006 instr_abort  in  1  fetch flush (branch taken); drop any pending or outstanding fetch.
REQ-007 instr_ready  out  1  one-cycle pulse: instr_rdata valid.
REQ-008 instr_rdata  out  32  fetched instruction word.
REQ-009 data_valid  in  1  load/store request; held with payload until data_ready.
REQ-010 data_addr  in  32; data_write  in  1; data_wmask  in  4; data_wdata  in  32  data request payload.
REQ-011 data_ready  out  1  one-cycle pulse: data access complete, data_rdata valid for loads.
REQ-012 data_rdata  out  32  load data.
REQ-013 bus_valid  out  1  shared memory port request, held until bus_ready.
REQ-014 bus_addr  out  32; bus_write  out  1; bus_wmask  out  4; bus_wdata  out  32  bus payload.
REQ-015 bus_ready  in  1  memory completion for the current bus_valid transaction.
REQ-016 bus_rdata  in  32  read data, valid when bus_ready=1.

Function
REQ-017 States: IDLE, BUSY_I, BUSY_D, DONE; exactly one bus transaction outstanding at a time.
REQ-018 IDLE, no valid request: stay IDLE, bus_valid=0.
REQ-019 IDLE, only data_valid: grant data -> BUSY_D.
REQ-020 IDLE, only instr_valid and instr_abort=0: grant fetch -> BUSY_I.
REQ-021 IDLE, both valid: grant fetch if streak==MAX_DATA_STREAK, else grant data.
REQ-022 instr_valid with instr_abort=1 in the same cycle is treated as not valid.
REQ-023 Streak counter (4 bits): cleared on fetch grant; incremented on data grant while instr_valid=1; cleared on data grant while instr_valid=0; never exceeds MAX_DATA_STREAK.
REQ-024 On grant, the payload is registered; bus_valid=1 and payload appear the cycle after the grant decision and stay stable until bus_ready.
REQ-025 Fetch transactions drive bus_write=0, bus_wmask=4'b0000, bus_wdata=0.
REQ-026 BUSY_x with bus_ready=1: capture bus_rdata, drop bus_valid next cycle, enter DONE.
REQ-027 BUSY_x with bus_ready=0: hold all bus outputs.
REQ-028 DONE lasts exactly one cycle: pulse the owner's ready with the captured rdata, then return to IDLE; no grant is made in DONE.
REQ-029 Abort flag: set by instr_abort=1 in BUSY_I or DONE of a fetch; when set, the instr_ready pulse in DONE is suppressed; cleared on entry to IDLE.
REQ-030 The bus transaction of an aborted fetch still completes; it is never withdrawn.
REQ-031 instr_abort has no effect on data transactions or the streak counter.
REQ-032 instr_ready and data_ready are never both 1; bus_ready outside BUSY_x is ignored.
REQ-033 Minimum latency: request to bus_valid 1 cycle; bus_ready to owner ready 1 cycle; back-to-back period 3 cycles with zero-wait memory.

Reset
REQ-034 reset_n=0 immediately forces state IDLE, streak 0, abort flag 0, bus_valid=0, bus_write=0, bus_wmask=0, bus_addr=0, bus_wdata=0, instr_ready=0, data_ready=0, instr_rdata=0, data_rdata=0.
REQ-035 Reset mid-transaction abandons it; no ready pulse follows reset deassertion for that transaction.
REQ-036 First grant possible in the first clock edge after reset_n deasserts.

Verification
REQ-037 Fetch only: instr_valid, addr 0x100, bus_ready one cycle after bus_valid, bus_rdata 0x00000013 -> bus_valid at cycle 1, instr_ready with 0x00000013 at cycle 3.
REQ-038 Store: data_write=1, addr 0x2000, wmask 4'b0011, wdata 0xDEADBEEF -> bus payload identical, held through 3 wait cycles, data_ready one cycle after bus_ready.
REQ-039 Contention, MAX_DATA_STREAK=4, both valid continuously -> grant order D,D,D,D,I,D,D,D,D,I.
REQ-040 Abort: instr_abort during BUSY_I -> bus transaction completes, no instr_ready pulse, next pending data request granted from IDLE.
REQ-041 reset_n low during BUSY_D with bus_valid=1 -> all outputs 0 immediately, state IDLE, no data_ready after release.

Source files
------------

// File: rtl/rv32_bus_arbiter.sv
// rv32_bus_arbiter
//   Shares one memory port between an instruction-fetch requester and a
//   load/store requester. Only one bus transaction is outstanding at a time.
//   When both requesters want the port, data wins until MAX_DATA_STREAK
//   consecutive data grants have been made with a fetch waiting, then the
//   fetch is served. A taken-branch flush (instr_abort) drops a pending fetch
//   and silences the response of an outstanding one. The bus transaction of
//   a flushed fetch is never withdrawn.
//
// Ports
//   clk, reset_n                  clock, asynchronous active-low reset
//   instr_valid/addr/abort        fetch request, held until ready or abort
//   instr_ready/rdata             one-cycle fetch response pulse
//   data_valid/addr/write/wmask/wdata   load/store request, held until ready
//   data_ready/rdata              one-cycle load/store completion pulse
//   bus_valid/addr/write/wmask/wdata    memory request, held until bus_ready
//   bus_ready/rdata               memory completion and read data
module rv32_bus_arbiter #(
  parameter int unsigned MAX_DATA_STREAK = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        instr_valid,
  input  logic [31:0] instr_addr,
  input  logic        instr_abort,
  output logic        instr_ready,
  output logic [31:0] instr_rdata,
  input  logic        data_valid,
  input  logic [31:0] data_addr,
  input  logic        data_write,
  input  logic [3:0]  data_wmask,
  input  logic [31:0] data_wdata,
  output logic        data_ready,
  output logic [31:0] data_rdata,
  output logic        bus_valid,
  output logic [31:0] bus_addr,
  output logic        bus_write,
  output logic [3:0]  bus_wmask,
  output logic [31:0] bus_wdata,
  input  logic        bus_ready,
  input  logic [31:0] bus_rdata
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] BUSY_I = 2'd1;
  localparam logic [1:0] BUSY_D = 2'd2;
  localparam logic [1:0] DONE   = 2'd3;

  localparam logic [3:0] STREAK_MAX = 4'(MAX_DATA_STREAK);

  logic [1:0] state;
  logic       owner_instr;  // owner of the current (or just finished) transaction
  logic [3:0] streak;       // data grants made in a row while a fetch waited
  logic       abort_flag;   // outstanding fetch was flushed; its response is dropped

  logic fetch_req;
  logic grant_i;
  logic grant_d;

  // A fetch flagged with abort in the same cycle does not count as a request.
  assign fetch_req = instr_valid && !instr_abort;
  assign grant_i   = (state == IDLE) && fetch_req && (!data_valid || streak == STREAK_MAX);
  assign grant_d   = (state == IDLE) && data_valid && !grant_i;

  // The response pulse is decoded from DONE. Including instr_abort here lets
  // a flush that arrives during DONE itself still suppress the fetch response.
  assign instr_ready = (state == DONE) && owner_instr && !abort_flag && !instr_abort;
  assign data_ready  = (state == DONE) && !owner_instr;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: every register, the read-data holding registers included, is
      // cleared by the asynchronous reset so all outputs are zero the moment
      // reset_n falls, and a transaction in flight is abandoned.
      state       <= IDLE;
      owner_instr <= 1'b0;
      streak      <= 4'd0;
      abort_flag  <= 1'b0;
      bus_valid   <= 1'b0;
      bus_addr    <= 32'd0;
      bus_write   <= 1'b0;
      bus_wmask   <= 4'd0;
      bus_wdata   <= 32'd0;
      instr_rdata <= 32'd0;
      data_rdata  <= 32'd0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every branch
      // below sees the values from before this clock edge.
      case (state)
        IDLE: begin
          if (grant_i) begin
            state       <= BUSY_I;
            owner_instr <= 1'b1;
            streak      <= 4'd0;
            bus_valid   <= 1'b1;
            bus_addr    <= instr_addr;
            bus_write   <= 1'b0;
            bus_wmask   <= 4'd0;
            bus_wdata   <= 32'd0;
          end else if (grant_d) begin
            state       <= BUSY_D;
            owner_instr <= 1'b0;
            bus_valid   <= 1'b1;
            bus_addr    <= data_addr;
            bus_write   <= data_write;
            bus_wmask   <= data_wmask;
            bus_wdata   <= data_wdata;
            // The streak only grows while a fetch is actually waiting, and
            // saturates so the fetch is guaranteed the next contested slot.
            if (instr_valid) begin
              streak <= (streak == STREAK_MAX) ? streak : streak + 4'd1;
            end else begin
              streak <= 4'd0;
            end
          end
        end

        BUSY_I, BUSY_D: begin
          if (state == BUSY_I && instr_abort) begin
            abort_flag <= 1'b1;
          end
          if (bus_ready) begin
            bus_valid <= 1'b0;
            state     <= DONE;
            if (owner_instr) begin
              instr_rdata <= bus_rdata;
            end else begin
              data_rdata <= bus_rdata;
            end
          end
        end

        DONE: begin
          // No grant here; the flag is cleared on the way back to IDLE, so a
          // flush seen in DONE acts only through the combinational term.
          state      <= IDLE;
          abort_flag <= 1'b0;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rv32_bus_arbiter.sv
// tb_rv32_bus_arbiter
//   Scoreboard bench for rv32_bus_arbiter. A transaction-level reference
//   model, fed only by the bench's own stimulus and memory responder, pushes
//   expected bus transactions and expected ready pulses into queues; a
//   monitor on the falling edge pops and compares. Directed scenarios cover
//   the documented examples, then randomized traffic runs against the model.
`timescale 1ns/1ps
module tb_rv32_bus_arbiter;

  localparam int MAX = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        instr_valid;
  logic [31:0] instr_addr;
  logic        instr_abort;
  logic        instr_ready;
  logic [31:0] instr_rdata;
  logic        data_valid;
  logic [31:0] data_addr;
  logic        data_write;
  logic [3:0]  data_wmask;
  logic [31:0] data_wdata;
  logic        data_ready;
  logic [31:0] data_rdata;
  logic        bus_valid;
  logic [31:0] bus_addr;
  logic        bus_write;
  logic [3:0]  bus_wmask;
  logic [31:0] bus_wdata;
  logic        bus_ready;
  logic [31:0] bus_rdata;

  always #5 clk = ~clk;

  rv32_bus_arbiter #(.MAX_DATA_STREAK(MAX)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .instr_valid(instr_valid),
    .instr_addr (instr_addr),
    .instr_abort(instr_abort),
    .instr_ready(instr_ready),
    .instr_rdata(instr_rdata),
    .data_valid (data_valid),
    .data_addr  (data_addr),
    .data_write (data_write),
    .data_wmask (data_wmask),
    .data_wdata (data_wdata),
    .data_ready (data_ready),
    .data_rdata (data_rdata),
    .bus_valid  (bus_valid),
    .bus_addr   (bus_addr),
    .bus_write  (bus_write),
    .bus_wmask  (bus_wmask),
    .bus_wdata  (bus_wdata),
    .bus_ready  (bus_ready),
    .bus_rdata  (bus_rdata)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Memory contents as seen by the bus: a fixed function of the address.
  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    if (a == 32'h100) return 32'h0000_0013;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  typedef struct {
    int          at;
    logic [31:0] addr;
    logic        write;
    logic [3:0]  wmask;
    logic [31:0] wdata;
  } bus_exp_t;

  typedef struct {
    int          at;
    bit          is_instr;
    bit          aborted;
    bit          is_load;
    logic [31:0] rdata;
  } rsp_exp_t;

  bus_exp_t    bus_q[$];
  rsp_exp_t    rsp_q[$];
  logic [31:0] start_log[$];

  // ---------------- memory responder ----------------
  int resp_wait = 0;   // fixed wait cycles, or -1 for random 0..3
  bit stray_en  = 0;   // random bus_ready while no transaction is open
  bit in_txn    = 0;
  int wait_left = 0;

  always @(posedge clk) begin
    #2;
    if (!reset_n) begin
      in_txn    = 0;
      bus_ready = 1'b0;
    end else begin
      if (bus_valid && !in_txn) begin
        in_txn    = 1;
        wait_left = (resp_wait >= 0) ? resp_wait : int'($urandom_range(0, 3));
      end
      if (in_txn) begin
        if (wait_left == 0) begin
          bus_ready = 1'b1;
          bus_rdata = mem_fn(bus_addr);
          in_txn    = 0;
        end else begin
          wait_left--;
          bus_ready = 1'b0;
          bus_rdata = $urandom;
        end
      end else begin
        bus_ready = stray_en && ($urandom_range(0, 3) == 0);
        bus_rdata = $urandom;
      end
    end
  end

  // ---------------- reference model ----------------
  // Port is either free, owned by one requester, or in its response cycle.
  bit       m_owned;
  bit       m_respond;
  bit       m_txn_i;
  bit       m_abort;
  int       m_streak;
  bus_exp_t m_txn;

  always @(posedge clk or negedge reset_n) begin
    rsp_exp_t r;
    bit       want_i;
    if (!reset_n) begin
      m_owned   = 0;
      m_respond = 0;
      m_abort   = 0;
      m_streak  = 0;
      bus_q.delete();
      rsp_q.delete();
    end else begin
      cyc++;
      if (m_respond) begin
        m_respond = 0;
        m_abort   = 0;
      end else if (m_owned) begin
        if (m_txn_i && instr_abort) m_abort = 1;
        if (bus_ready) begin
          r.at       = cyc;
          r.is_instr = m_txn_i;
          r.aborted  = m_abort;
          r.is_load  = !m_txn.write;
          r.rdata    = mem_fn(m_txn.addr);
          rsp_q.push_back(r);
          m_owned   = 0;
          m_respond = 1;
        end
      end else begin
        want_i = instr_valid && !instr_abort;
        if (want_i && (!data_valid || m_streak == MAX)) begin
          m_txn   = '{at: cyc, addr: instr_addr, write: 1'b0, wmask: 4'd0, wdata: 32'd0};
          m_txn_i = 1;
          m_streak = 0;
          m_abort = 0;
          m_owned = 1;
          bus_q.push_back(m_txn);
        end else if (data_valid) begin
          m_txn   = '{at: cyc, addr: data_addr, write: data_write, wmask: data_wmask, wdata: data_wdata};
          m_txn_i = 0;
          m_streak = instr_valid ? ((m_streak < MAX) ? m_streak + 1 : MAX) : 0;
          m_abort = 0;
          m_owned = 1;
          bus_q.push_back(m_txn);
        end
      end
    end
  end

  // ---------------- monitor ----------------
  bus_exp_t cur_bus;
  logic     mon_prev_bv = 1'b0;
  int       last_start_cyc = -1;
  int       last_ready_cyc = -1;
  bit       i_ack = 0;
  bit       d_ack = 0;

  always @(negedge clk) begin
    rsp_exp_t r;
    bit       exp_i;
    bit       exp_d;
    bit       exp_load;
    if (!reset_n) begin
      mon_prev_bv = 1'b0;
    end else begin
      while (bus_q.size() > 0 && bus_q[0].at < cyc) begin
        check("bus_start_late", 72'(cyc), 72'(bus_q[0].at));
        void'(bus_q.pop_front());
      end
      if (bus_valid && !mon_prev_bv) begin
        last_start_cyc = cyc;
        start_log.push_back(bus_addr);
        if (bus_q.size() == 0) begin
          check("bus_start_unexpected", 72'(bus_valid), 72'(0));
        end else begin
          cur_bus = bus_q.pop_front();
          check("bus_start_cycle", 72'(cyc), 72'(cur_bus.at));
          check("bus_payload", {bus_addr, bus_write, bus_wmask, bus_wdata},
                {cur_bus.addr, cur_bus.write, cur_bus.wmask, cur_bus.wdata});
        end
      end else if (bus_valid) begin
        check("bus_payload_hold", {bus_addr, bus_write, bus_wmask, bus_wdata},
              {cur_bus.addr, cur_bus.write, cur_bus.wmask, cur_bus.wdata});
      end
      if (bus_valid && bus_ready) last_ready_cyc = cyc;
      mon_prev_bv = bus_valid;

      exp_i = 0;
      exp_d = 0;
      exp_load = 0;
      if (rsp_q.size() > 0 && rsp_q[0].at == cyc) begin
        r = rsp_q.pop_front();
        if (r.is_instr) exp_i = !r.aborted && !instr_abort;
        else begin
          exp_d    = 1;
          exp_load = r.is_load;
        end
      end
      check("instr_ready", 72'(instr_ready), 72'(exp_i));
      check("data_ready", 72'(data_ready), 72'(exp_d));
      if (exp_i) check("instr_rdata", 72'(instr_rdata), 72'(r.rdata));
      if (exp_load) check("data_rdata", 72'(data_rdata), 72'(r.rdata));
      if (instr_ready) i_ack = 1;
      if (data_ready) d_ack = 1;
    end
  end

  // ---------------- random requesters ----------------
  bit rand_en = 0;

  always @(posedge clk) begin
    bit ack_i;
    bit ack_d;
    #2;
    ack_i = i_ack;
    ack_d = d_ack;
    i_ack = 0;
    d_ack = 0;
    if (rand_en && reset_n) begin
      if (instr_abort) begin
        instr_abort = 1'b0;
        instr_valid = 1'b0;
      end else if (instr_valid && ack_i) begin
        instr_valid = 1'b0;
      end else if (instr_valid && $urandom_range(0, 9) == 0) begin
        instr_abort = 1'b1;  // flush while the fetch is still presented
      end else if (!instr_valid && $urandom_range(0, 40) == 0) begin
        instr_abort = 1'b1;  // flush with nothing pending
      end
      if (!instr_valid && !instr_abort && $urandom_range(0, 2) == 0) begin
        instr_valid = 1'b1;
        instr_addr  = 32'h1000 | {22'd0, 8'($urandom), 2'b00};
      end
      if (data_valid && ack_d) data_valid = 1'b0;
      if (!data_valid && $urandom_range(0, 1) == 0) begin
        data_valid = 1'b1;
        data_addr  = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
        data_write = 1'($urandom);
        data_wmask = 4'($urandom);
        data_wdata = $urandom;
      end
    end
  end

  // ---------------- directed helpers ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // kind 0: instr_ready, 1: data_ready, 2: bus_valid
  task automatic wait_for(input int kind, input int budget, input string name, output int at);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if ((kind == 0 && instr_ready) || (kind == 1 && data_ready) || (kind == 2 && bus_valid)) begin
        at = cyc;
        break;
      end
    end
    check(name, 72'(at >= 0), 72'(1));
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_bus_valid"},   72'(bus_valid),   72'(0));
    check({tag, "_bus_addr"},    72'(bus_addr),    72'(0));
    check({tag, "_bus_write"},   72'(bus_write),   72'(0));
    check({tag, "_bus_wmask"},   72'(bus_wmask),   72'(0));
    check({tag, "_bus_wdata"},   72'(bus_wdata),   72'(0));
    check({tag, "_instr_ready"}, 72'(instr_ready), 72'(0));
    check({tag, "_data_ready"},  72'(data_ready),  72'(0));
    check({tag, "_instr_rdata"}, 72'(instr_rdata), 72'(0));
    check({tag, "_data_rdata"},  72'(data_rdata),  72'(0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int    req_cyc;
    int    at;
    int    f_ready;
    int    i_pulses;
    int    d_pulses;
    string pat;
    logic [31:0] fetch_word;

    reset_n = 1'b0;
    instr_valid = 1'b0; instr_addr = '0; instr_abort = 1'b0;
    data_valid = 1'b0; data_addr = '0; data_write = 1'b0; data_wmask = '0; data_wdata = '0;
    bus_ready = 1'b0; bus_rdata = '0;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    tick();
    reset_n = 1'b1;
    repeat (2) tick();

    // Fetch only: grant next cycle, instr_ready two cycles after bus_valid.
    resp_wait = 1;
    instr_valid = 1'b1;
    instr_addr  = 32'h100;
    req_cyc     = cyc;
    wait_for(0, 20, "fetch_timeout", at);
    fetch_word = instr_rdata;
    check("fetch_bus_valid_cycle", 72'(last_start_cyc - req_cyc), 72'(1));
    check("fetch_ready_cycle", 72'(at - req_cyc), 72'(3));
    check("fetch_word", 72'(fetch_word), 72'(32'h0000_0013));
    tick();
    instr_valid = 1'b0;
    repeat (2) tick();

    // Store with three wait cycles.
    resp_wait  = 3;
    data_valid = 1'b1;
    data_write = 1'b1;
    data_addr  = 32'h2000;
    data_wmask = 4'b0011;
    data_wdata = 32'hDEAD_BEEF;
    wait_for(1, 30, "store_timeout", at);
    check("store_wait_cycles", 72'(last_ready_cyc - last_start_cyc), 72'(3));
    check("store_ready_latency", 72'(at - last_ready_cyc), 72'(1));
    tick();
    data_valid = 1'b0;
    data_write = 1'b0;
    repeat (2) tick();

    // Continuous contention: data wins MAX times, then the fetch.
    resp_wait   = 0;
    start_log.delete();
    instr_valid = 1'b1;
    instr_addr  = 32'h100;
    data_valid  = 1'b1;
    data_write  = 1'b0;
    data_addr   = 32'h3000;
    for (int i = 0; i < 100 && start_log.size() < 10; i++) @(negedge clk);
    check("contention_count", 72'(start_log.size() >= 10), 72'(1));
    pat = "DDDDIDDDDI";
    for (int i = 0; i < 10 && i < start_log.size(); i++) begin
      check($sformatf("grant_order_%0d", i), 72'(start_log[i] == 32'h100), 72'(pat[i] == "I"));
    end
    tick();
    instr_valid = 1'b0;
    data_valid  = 1'b0;
    repeat (8) tick();

    // Abort during BUSY_I: transaction completes silently, data granted next.
    resp_wait   = 3;
    instr_valid = 1'b1;
    instr_addr  = 32'h100;
    wait_for(2, 20, "abort_fetch_start_timeout", at);
    tick();
    instr_abort = 1'b1;
    instr_valid = 1'b0;
    data_valid  = 1'b1;
    data_write  = 1'b0;
    data_addr   = 32'h4000;
    tick();
    instr_abort = 1'b0;
    i_pulses = 0;
    f_ready  = -1;
    at       = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (instr_ready) i_pulses++;
      if (bus_valid && bus_ready && bus_addr == 32'h100) f_ready = cyc;
      if (data_ready) begin
        at = cyc;
        break;
      end
    end
    check("abort_data_timeout", 72'(at >= 0), 72'(1));
    check("abort_no_instr_ready", 72'(i_pulses), 72'(0));
    check("abort_next_grant_addr", 72'(start_log[start_log.size() - 1]), 72'(32'h4000));
    check("abort_next_grant_cycle", 72'(last_start_cyc), 72'(f_ready + 3));
    tick();
    data_valid = 1'b0;
    repeat (4) tick();

    // Reset during BUSY_D: immediate clear, no stale data_ready, grant on first edge.
    resp_wait  = 6;
    data_valid = 1'b1;
    data_write = 1'b0;
    data_addr  = 32'h5000;
    wait_for(2, 20, "reset_txn_start_timeout", at);
    #1;
    reset_n = 1'b0;
    #1;
    check_outputs_zero("async_reset");
    data_valid  = 1'b0;
    instr_valid = 1'b1;
    instr_addr  = 32'h100;
    repeat (2) tick();
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    check("first_grant_valid", 72'(bus_valid), 72'(1));
    check("first_grant_addr", 72'(bus_addr), 72'(32'h100));
    d_pulses = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (data_ready) d_pulses++;
    end
    check("no_data_ready_after_reset", 72'(d_pulses), 72'(0));
    wait_for(0, 40, "post_reset_fetch_timeout", at);
    tick();
    instr_valid = 1'b0;
    repeat (4) tick();

    // Randomized traffic against the model.
    resp_wait = -1;
    stray_en  = 1;
    i_ack     = 0;
    d_ack     = 0;
    rand_en   = 1;
    repeat (3000) @(posedge clk);
    rand_en = 0;
    #3;
    instr_valid = 1'b0;
    instr_abort = 1'b0;
    data_valid  = 1'b0;
    stray_en    = 0;
    repeat (20) tick();
    check("drain_bus_queue", 72'(bus_q.size()), 72'(0));
    check("drain_rsp_queue", 72'(rsp_q.size()), 72'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
